// File: rtl/ysyx_22041461_shift_pipe.sv
// rtl/ysyx_22041461_shift_pipe.sv - pipelined SLL/SRL/SRA shift unit with RV64 word forms
//
// Purpose:
//   Shift unit beside the ALU. Ops flow through STAGES register stages. The log2(XLEN)
//   power-of-two mux levels are split evenly across the stages. Each stage has a valid
//   bit and a valid/ready handshake, so ops are never dropped or duplicated. A flush
//   input kills every op in flight.
//
// Optional feature:
//   YSYX_SHIFT_ROTATE_EN - op 3 = ROL, op 7 = ROR (RORW when XLEN=64).
//   When the macro is undefined, ops 3/7 return 0 and no rotate logic is built.
//
// Ports:
//   clk, rst                 clock (rising edge); synchronous active-high reset
//   flush                    drop all in-flight ops; blocks acceptance this cycle
//   in_valid / in_ready      input handshake
//   in_op                    0 SLL, 1 SRL, 2 SRA, 4 SLLW, 5 SRLW, 6 SRAW, 3/7 rotate or undefined
//   in_src1, in_src2         value to shift; shift amount (low SHW bits, or low 5 bits for word ops)
//   in_tag                   opaque tag, returned with the result
//   out_valid / out_ready    output handshake
//   out_res, out_tag         result and its tag
module ysyx_22041461_shift_pipe #(
   parameter int XLEN   = 64,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_res,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [2:0] K_SLL = 3'd0;
   localparam logic [2:0] K_SRL = 3'd1;
   localparam logic [2:0] K_SRA = 3'd2;
`ifdef YSYX_SHIFT_ROTATE_EN
   localparam logic [2:0] K_ROL = 3'd3;
   localparam logic [2:0] K_ROR = 3'd4;
`endif

   typedef struct packed {
      logic [XLEN-1:0]  val;
      logic [SHW-1:0]   amt;
      logic [2:0]       kind;
      logic             word;
      logic [TAG_W-1:0] tag;
   } pl_t;

   pl_t               in_pl;
   pl_t               st_d [STAGES];
   pl_t               st_q [STAGES];
   logic [STAGES-1:0] st_v;
   logic [STAGES-1:0] can_load;
   logic              accept;
   logic              word_op;
   logic              unused_src2;

   // Only the low shift-amount bits matter; the rest is intentionally ignored.
   assign unused_src2 = ^in_src2[XLEN-1:SHW];

   // One mux level: move by n positions (n is a power of two below XLEN).
   function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] v,
                                                 input logic [2:0]      kind,
                                                 input int              n);
      logic [XLEN-1:0] r;
      case (kind)
         K_SLL:   r = v << n;
         K_SRL:   r = v >> n;
         K_SRA:   r = XLEN'($signed(v) >>> n);
`ifdef YSYX_SHIFT_ROTATE_EN
         K_ROL:   r = (v << n) | (v >> (XLEN - n));
         K_ROR:   r = (v >> n) | (v << (XLEN - n));
`endif
         default: r = v;
      endcase
      return r;
   endfunction

   assign word_op = (XLEN == 64) && in_op[2];

   // Decode: word ops are pre-extended so the full-width shifter yields the right
   // low 32 bits. The last stage then sign-extends bit 31.
   always_comb begin
      in_pl      = '0;
      in_pl.word = word_op;
      in_pl.tag  = in_tag;
      in_pl.amt  = in_src2[SHW-1:0] & (word_op ? SHW'(31) : {SHW{1'b1}});
      case (in_op[1:0])
         2'd0: begin
            in_pl.kind = K_SLL;
            in_pl.val  = in_src1;
         end
         2'd1: begin
            in_pl.kind = K_SRL;
            in_pl.val  = word_op ? XLEN'(in_src1[31:0]) : in_src1;
         end
         2'd2: begin
            in_pl.kind = K_SRA;
            in_pl.val  = word_op ? XLEN'($signed(in_src1[31:0])) : in_src1;
         end
         default: begin
`ifdef YSYX_SHIFT_ROTATE_EN
            // RORW rotates a doubled copy of the low word; an amount below 32 leaves
            // the 32-bit rotation in the low half.
            in_pl.kind = in_op[2] ? K_ROR : K_ROL;
            in_pl.val  = word_op ? ((XLEN'(in_src1[31:0]) << 32) | XLEN'(in_src1[31:0]))
                                 : in_src1;
`else
            // Undefined op: shifting a zero operand gives a zero result.
            in_pl.kind = K_SLL;
            in_pl.val  = '0;
`endif
         end
      endcase
   end

   // Backpressure chain from the output back to the input.
   always_comb begin : ready_chain
      logic nxt;
      nxt      = out_ready;
      can_load = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         nxt         = ~st_v[k] | nxt;
         can_load[k] = nxt;
      end
   end

   assign in_ready = can_load[0] & ~flush;
   assign accept   = in_valid & in_ready;

   // Per-stage combinational logic: stage k applies levels [lo, hi).
   always_comb begin : datapath
      pl_t             node;
      logic [XLEN-1:0] v;
      int              lo;
      int              hi;
      for (int k = 0; k < STAGES; k++) begin
         node = (k == 0) ? in_pl : st_q[(k == 0) ? 0 : k - 1];
         lo   = (k * SHW) / STAGES;
         hi   = ((k + 1) * SHW) / STAGES;
         v    = node.val;
         for (int i = 0; i < SHW; i++) begin
            if (i >= lo && i < hi && node.amt[i]) begin
               v = shift_lvl(v, node.kind, 1 << i);
            end
         end
         if (k == STAGES - 1 && node.word) begin
            for (int b = 32; b < XLEN; b++) begin
               v[b] = v[31];
            end
         end
         st_d[k]     = node;
         st_d[k].val = v;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_v <= '0;
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (can_load[k]) begin
               st_v[k] <= (k == 0) ? accept : st_v[(k == 0) ? 0 : k - 1];
               // Data moves only with a real op, so out_res holds between results.
               if ((k == 0) ? accept : st_v[(k == 0) ? 0 : k - 1]) begin
                  st_q[k] <= st_d[k];
               end
            end
         end
         if (flush) begin
            st_v <= '0;
         end
      end
   end

   assign out_valid = st_v[STAGES-1];
   assign out_res   = st_q[STAGES-1].val;
   assign out_tag   = st_q[STAGES-1].tag;

endmodule

// File: tb/tb_ysyx_22041461_shift_pipe.sv
// tb/tb_ysyx_22041461_shift_pipe.sv - randomized scoreboard bench for the shift pipe
module tb_ysyx_22041461_shift_pipe;

   localparam int XLEN   = 64;
   localparam int STAGES = 2;
   localparam int TAG_W  = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [XLEN-1:0]  in_src1;
   logic [XLEN-1:0]  in_src2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_res;
   logic [TAG_W-1:0] out_tag;

   always #5 clk = ~clk;

   ysyx_22041461_shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag)
   );

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   next_ok  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] sext32(input logic [31:0] w);
      return {{32{w[31]}}, w};
   endfunction

   function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      int          s6;
      int          s5;
      logic [31:0] lo;
      logic [63:0] r;
      s6 = int'(b[5:0]);
      s5 = int'(b[4:0]);
      lo = a[31:0];
      r  = '0;
      case (op)
         3'd0: r = a << s6;
         3'd1: r = a >> s6;
         3'd2: r = $signed(a) >>> s6;
         3'd4: r = sext32(lo << s5);
         3'd5: r = sext32(lo >> s5);
         3'd6: r = sext32($signed(lo) >>> s5);
`ifdef YSYX_SHIFT_ROTATE_EN
         3'd3: r = (a << s6) | (a >> (64 - s6));
         3'd7: r = sext32((lo >> s5) | (lo << (32 - s5)));
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // One clock cycle: drive, check against the model, then update the model.
   task automatic step(input bit offer, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input bit ordy,
                       input bit fl, output bit acc, output bit ov);
      bit   deq;
      bit   exp_v;
      bit   exp_rdy;
      exp_t e;
      @(negedge clk);
      in_valid  = offer;
      in_op     = op;
      in_src1   = a;
      in_src2   = b;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_v = 1'b0;
      if (sb.size() > 0) exp_v = (cyc >= sb[0].due) && (cyc >= next_ok);
      exp_rdy = !fl && ((sb.size() < STAGES) || ordy);
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, exp_rdy);
      if (out_valid && exp_v) begin
         check("out_res", out_res, sb[0].res);
         check("out_tag", out_tag, sb[0].tag);
      end
      acc = offer && in_ready;
      deq = out_valid && ordy;
      ov  = out_valid;
      @(posedge clk);
      if (deq && sb.size() > 0) begin
         void'(sb.pop_front());
         next_ok = cyc + 1;
      end
      if (fl) sb.delete();
      if (acc && !fl) begin
         e.res = ref_shift(op, a, b);
         e.tag = tag;
         e.due = cyc + STAGES;
         sb.push_back(e);
      end
      cyc++;
   endtask

   // Single op with a fixed expected value; also measures latency.
   task automatic directed(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag,
                           input logic [63:0] exp);
      bit   acc;
      bit   ov;
      int   lat;
      exp_t e;
      step(1'b1, op, a, b, tag, 1'b1, 1'b0, acc, ov);
      check({name, "_acc"}, 64'(acc), 64'd1);
      if (acc && sb.size() > 0) begin
         e     = sb.pop_back();
         e.res = exp;
         sb.push_back(e);
      end
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         lat++;
         step(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, acc, ov);
         if (ov) break;
      end
      check({name, "_lat"}, 64'(lat), 64'(STAGES));
   endtask

   logic [63:0] sa [8];
   logic [63:0] sbv[8];

   initial begin
      bit acc;
      bit ov;
      int idx;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
      in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_res", out_res, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      directed("srl", 3'd1, 64'hF000_0000_0000_0001, 64'h44, 5'd1, 64'h0F00_0000_0000_0000);
      directed("sra", 3'd2, 64'hF000_0000_0000_0001, 64'h44, 5'd2, 64'hFF00_0000_0000_0000);
      directed("srlw0", 3'd5, 64'h1234_5678_8000_0000, 64'h0, 5'd3, 64'hFFFF_FFFF_8000_0000);
      directed("sraw31", 3'd6, 64'h8000_0000, 64'd31, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      directed("sllw31", 3'd4, 64'h1, 64'd31, 5'd5, 64'hFFFF_FFFF_8000_0000);
      directed("sll63", 3'd0, 64'h3, 64'd63, 5'd6, 64'h8000_0000_0000_0000);
      directed("sra0", 3'd2, 64'h8000_0000_0000_0005, 64'h40, 5'd7, 64'h8000_0000_0000_0005);
`ifdef YSYX_SHIFT_ROTATE_EN
      directed("rorw1", 3'd7, 64'h1, 64'd1, 5'd9, 64'hFFFF_FFFF_8000_0000);
      directed("rol1", 3'd3, 64'h8000_0000_0000_0000, 64'd1, 5'd10, 64'h1);
`else
      directed("op7", 3'd7, 64'h1, 64'd1, 5'd9, 64'h0);
      directed("op3", 3'd3, 64'hFFFF, 64'd4, 5'd10, 64'h0);
`endif

      // Back-to-back SLL stream with a 5-cycle output stall.
      for (int i = 0; i < 8; i++) begin
         sa[i]  = {$urandom, $urandom};
         sbv[i] = 64'($urandom_range(0, 63));
      end
      idx = 0;
      for (int c = 0; c < 60 && (idx < 8 || sb.size() > 0); c++) begin
         step(idx < 8, 3'd0, sa[idx & 7], sbv[idx & 7], 5'(idx), !(c >= 3 && c < 8),
              1'b0, acc, ov);
         if (acc) idx++;
      end
      check("stream_sent", 64'(idx), 64'd8);
      check("stream_empty", 64'(sb.size()), 64'd0);

      // Flush with a full pipe and an input offered.
      for (int c = 0; c < 10 && sb.size() < STAGES; c++) begin
         step(1'b1, 3'd1, {$urandom, $urandom}, 64'($urandom_range(0, 63)), 5'(20 + c),
              1'b0, 1'b0, acc, ov);
      end
      check("flush_fill", 64'(sb.size()), 64'(STAGES));
      step(1'b1, 3'd2, 64'hDEAD_BEEF_0000_0001, 64'd3, 5'd30, 1'b0, 1'b1, acc, ov);
      check("flush_noacc", 64'(acc), 64'd0);
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, acc, ov);
      end

      // Random traffic with random backpressure and occasional flushes.
      for (int c = 0; c < 500; c++) begin
         logic [63:0] a;
         logic [63:0] b;
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
         b = {$urandom, $urandom};
         step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), a, b,
              5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0, acc, ov);
      end
      for (int c = 0; c < 20 && sb.size() > 0; c++) begin
         step(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, acc, ov);
      end
      check("drain_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
